// File: rtl/png_quarantine_fifo.sv
// Quarantine FIFO for PNG-flagged records; presents them to the FTP-side buffer (optional stats: PNG_QFIFO_STATS_EN).
// Latency: push visible one cycle later (first-word fall-through); pops sustain one record per cycle.
// Backpressure: out_ready stalls the head only; the classifier is never stalled, overflowing records are dropped.
module png_quarantine_fifo #(
    parameter int          DATA_WIDTH    = 256,
    parameter int          PAYLOAD_WIDTH = DATA_WIDTH*3-432,
    parameter int          DEPTH         = 8,
    parameter logic [15:0] FTP_PORT      = 16'd21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_decision,
    input  logic [PAYLOAD_WIDTH-1:0]   in_data,
    input  logic [31:0]                in_ip,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PAYLOAD_WIDTH-1:0]   out_data,
    output logic [31:0]                out_ip,
    output logic [15:0]                out_port,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [15:0]                drop_count,
    output logic [15:0]                accept_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0]              ip;
        logic [PAYLOAD_WIDTH-1:0] dat;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          flagged;
    logic          push;
    logic          pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign count     = count_q;
    assign out_valid = !empty;

    assign flagged = in_valid & in_decision;
    assign pop     = out_valid & out_ready;
    // A pop frees the slot this same edge, so a full FIFO can still take a record.
    assign push    = flagged & (!full | pop);

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head.dat : '0;
    assign out_ip   = out_valid ? head.ip  : 32'd0;
    assign out_port = out_valid ? FTP_PORT : 16'd0;

    // Storage is not reset; stale entries are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= '{ip: in_ip, dat: in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef PNG_QFIFO_STATS_EN
    logic [15:0] drop_q;
    logic [15:0] accept_q;
    logic        drop;

    assign drop = flagged & full & !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q   <= 16'd0;
            accept_q <= 16'd0;
        end else begin
            if (drop && drop_q != 16'hFFFF)   drop_q   <= drop_q + 16'd1;
            if (push && accept_q != 16'hFFFF) accept_q <= accept_q + 16'd1;
        end
    end

    assign drop_count   = drop_q;
    assign accept_count = accept_q;
`else
    assign drop_count   = 16'd0;
    assign accept_count = 16'd0;
`endif

endmodule

// File: tb/tb_png_quarantine_fifo.sv
// Directed bench for png_quarantine_fifo: fill, drop, full-with-pop, streaming wrap, mid-run reset.
module tb_png_quarantine_fifo;
    localparam int PW = 336;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_decision;
    logic [PW-1:0] in_data;
    logic [31:0]   in_ip;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [31:0]   out_ip;
    logic [15:0]   out_port;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic [15:0]   drop_count;
    logic [15:0]   accept_count;

    int n_vec = 0;
    int n_err = 0;

    png_quarantine_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_decision  (in_decision),
        .in_data      (in_data),
        .in_ip        (in_ip),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ip       (out_ip),
        .out_port     (out_port),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .drop_count   (drop_count),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stats ports read zero unless the stats build is selected.
    function automatic logic [15:0] stat(input int v);
`ifdef PNG_QFIFO_STATS_EN
        return 16'(v);
`else
        return 16'd0 + 16'(v * 0);
`endif
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply(input logic v, input logic dec, input logic [31:0] ip,
                         input logic [PW-1:0] d, input logic rdy);
        in_valid    = v;
        in_decision = dec;
        in_ip       = ip;
        in_data     = d;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        apply(1'b0, 1'b0, 32'd0, '0, rdy);
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;

        chk("rst_count", PW'(count), PW'(0));
        chk("rst_valid", PW'(out_valid), PW'(0));
        chk("rst_empty", PW'(empty), PW'(1));
        chk("rst_full", PW'(full), PW'(0));
        chk("rst_data", out_data, '0);
        chk("rst_ip", PW'(out_ip), PW'(0));
        chk("rst_port", PW'(out_port), PW'(0));
        chk("rst_drop", PW'(drop_count), PW'(stat(0)));

        // Three flagged records, consumer stalled.
        for (int i = 1; i <= 3; i++) apply(1'b1, 1'b1, 32'h0A00_0000 + 32'(i), PW'(i), 1'b0);
        chk("p3_count", PW'(count), PW'(3));
        chk("p3_valid", PW'(out_valid), PW'(1));
        chk("p3_ip", PW'(out_ip), PW'(32'h0A00_0001));
        chk("p3_data", out_data, PW'(1));
        chk("p3_port", PW'(out_port), PW'(21));
        chk("p3_accept", PW'(accept_count), PW'(stat(3)));

        // Unflagged record must leave no trace.
        apply(1'b1, 1'b0, 32'hC0A8_0001, PW'(32'h55), 1'b0);
        chk("nf_count", PW'(count), PW'(3));
        chk("nf_accept", PW'(accept_count), PW'(stat(3)));

        // Fill to 8, then two overflow strobes.
        for (int i = 4; i <= 8; i++) apply(1'b1, 1'b1, 32'h0A00_0000 + 32'(i), PW'(i), 1'b0);
        chk("fill_full", PW'(full), PW'(1));
        chk("fill_count", PW'(count), PW'(8));
        apply(1'b1, 1'b1, 32'hDEAD_0001, PW'(32'hDEAD), 1'b0);
        apply(1'b1, 1'b1, 32'hDEAD_0002, PW'(32'hDEAD), 1'b0);
        idle(1'b0);
        chk("ovf_count", PW'(count), PW'(8));
        chk("ovf_drop", PW'(drop_count), PW'(stat(2)));
        chk("ovf_stable_ip", PW'(out_ip), PW'(32'h0A00_0001));
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain1_ip%0d", i), PW'(out_ip), PW'(32'h0A00_0000 + 32'(i)));
            chk($sformatf("drain1_dat%0d", i), out_data, PW'(i));
            idle(1'b1);
        end
        chk("drain1_empty", PW'(empty), PW'(1));
        chk("drain1_ip0", PW'(out_ip), PW'(0));
        chk("drain1_port0", PW'(out_port), PW'(0));

        // Full with simultaneous push and pop: no drop, new record lands at the tail.
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 32'h0B00_0000 + 32'(i), PW'(32'h100 + i), 1'b0);
        apply(1'b1, 1'b1, 32'h0BBB_BBBB, PW'(32'h1FF), 1'b1);
        chk("fpp_count", PW'(count), PW'(8));
        chk("fpp_full", PW'(full), PW'(1));
        chk("fpp_drop", PW'(drop_count), PW'(stat(2)));
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain2_ip%0d", i), PW'(out_ip),
                PW'((i == 8) ? 32'h0BBB_BBBB : 32'h0B00_0000 + 32'(i)));
            idle(1'b1);
        end
        chk("drain2_empty", PW'(empty), PW'(1));

        // Streaming: push every cycle with out_ready held high; pointers wrap repeatedly.
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 32'h0C00_0000 + 32'(i), PW'(32'h200 + i), 1'b1);
            chk($sformatf("strm_ip%0d", i), PW'(out_ip), PW'(32'h0C00_0000 + 32'(i)));
            chk($sformatf("strm_cnt%0d", i), PW'(count), PW'(1));
        end
        idle(1'b1);
        chk("strm_empty", PW'(empty), PW'(1));
        chk("strm_drop", PW'(drop_count), PW'(stat(2)));
        chk("strm_accept", PW'(accept_count), PW'(stat(37)));

        // Reset with records stored and a push coinciding with rst.
        for (int i = 1; i <= 4; i++) apply(1'b1, 1'b1, 32'h0D00_0000 + 32'(i), PW'(i), 1'b0);
        chk("pre_rst_count", PW'(count), PW'(4));
        rst = 1'b1;
        apply(1'b1, 1'b1, 32'hEEEE_EEEE, PW'(32'hEE), 1'b0);
        rst = 1'b0;
        chk("mrst_count", PW'(count), PW'(0));
        chk("mrst_valid", PW'(out_valid), PW'(0));
        chk("mrst_data", out_data, '0);
        chk("mrst_drop", PW'(drop_count), PW'(0));
        chk("mrst_accept", PW'(accept_count), PW'(0));
        apply(1'b1, 1'b1, 32'h0F00_0001, PW'(32'h77), 1'b0);
        chk("post_ip", PW'(out_ip), PW'(32'h0F00_0001));
        chk("post_data", out_data, PW'(32'h77));
        chk("post_count", PW'(count), PW'(1));
        chk("post_accept", PW'(accept_count), PW'(stat(1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
